// File: rtl/debounce_pkg.sv
// Shared types for the debounce conditioning stage: FSM state encoding and
// the counter-width helper used to size the debounce counter.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LO       = 2'd0,
    ST_LO_TO_HI = 2'd1,
    ST_HI       = 2'd2,
    ST_HI_TO_LO = 2'd3
  } db_state_t;

  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_sync_chain.sv
// Plain N-flop synchronizer for one asynchronous level; reusable for any
// async input that needs to be brought into the clk domain.
module sync_chain #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes a raw async level, debounces it per direction and emits a
// registered clean level with one-cycle rise/fall/glitch pulses.
module debounce_sync #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a_async,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic glitch
);

  import debounce_pkg::*;

  localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam db_state_t         ST_RESET = RESET_LEVEL ? ST_HI : ST_LO;

  logic             s;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             glitch_q, glitch_d;

  sync_chain #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (a_async),
    .q   (s)
  );

  // cnt holds how many consecutive cycles the new level has been seen so far
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clean_d  = clean_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = 1'b0;
    case (state_q)
      ST_LO: begin
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = ST_HI;
            clean_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = ST_LO_TO_HI;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_LO_TO_HI: begin
        if (!s) begin
          state_d  = ST_LO;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HI;
          cnt_d   = '0;
          clean_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HI: begin
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = ST_LO;
            clean_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = ST_HI_TO_LO;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_HI_TO_LO: begin
        if (s) begin
          state_d  = ST_HI;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LO;
          cnt_d   = '0;
          clean_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RESET;
      cnt_q    <= '0;
      clean_q  <= RESET_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clean_q  <= clean_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign clean  = clean_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign glitch = glitch_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: default instance plus a 3-stage/1-cycle instance,
// both checked every cycle against a run-length model and at pinned points.
module tb_debounce_sync;

  typedef struct packed {
    logic [7:0] pipe;
    int         run;
    logic       clean;
    logic       rise;
    logic       fall;
    logic       glitch;
  } model_t;

  logic clk;
  logic rst;
  logic a_async;
  logic clean0, rise0, fall0, glitch0;
  logic clean1, rise1, fall1, glitch1;

  model_t m0;
  model_t m1;
  bit     started;
  int     n_assert;
  int     n_fail;

  debounce_sync #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_LEVEL     (1'b0)
  ) dut0 (
    .clk     (clk),
    .rst     (rst),
    .a_async (a_async),
    .clean   (clean0),
    .rise    (rise0),
    .fall    (fall0),
    .glitch  (glitch0)
  );

  debounce_sync #(
    .SYNC_STAGES     (3),
    .DEBOUNCE_CYCLES (1),
    .RESET_LEVEL     (1'b0)
  ) dut1 (
    .clk     (clk),
    .rst     (rst),
    .a_async (a_async),
    .clean   (clean1),
    .rise    (rise1),
    .fall    (fall1),
    .glitch  (glitch1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // s seen at an edge is the input from stages edges ago; clean flips once
  // the run of differing samples reaches the window, an interrupted run is a glitch
  function automatic model_t model_step(model_t m, logic a, logic r,
                                        int stages, int window, logic rl);
    model_t n;
    logic   s;
    n        = m;
    n.rise   = 1'b0;
    n.fall   = 1'b0;
    n.glitch = 1'b0;
    if (r) begin
      n.pipe  = {8{rl}};
      n.run   = 0;
      n.clean = rl;
      return n;
    end
    s      = m.pipe[stages-1];
    n.pipe = {m.pipe[6:0], a};
    if (s != m.clean) begin
      n.run = m.run + 1;
      if (n.run >= window) begin
        n.clean = s;
        n.rise  = s;
        n.fall  = ~s;
        n.run   = 0;
      end
    end else if (m.run > 0) begin
      n.glitch = 1'b1;
      n.run    = 0;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m0 = model_step(m0, a_async, rst, 2, 4, 1'b0);
    m1 = model_step(m1, a_async, rst, 3, 1, 1'b0);
    started = 1'b1;
  end

  task automatic checkBit(input string name, input logic act, input logic exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      checkBit("model dut0 clean",  clean0,  m0.clean);
      checkBit("model dut0 rise",   rise0,   m0.rise);
      checkBit("model dut0 fall",   fall0,   m0.fall);
      checkBit("model dut0 glitch", glitch0, m0.glitch);
      checkBit("model dut1 clean",  clean1,  m1.clean);
      checkBit("model dut1 rise",   rise1,   m1.rise);
      checkBit("model dut1 fall",   fall1,   m1.fall);
      checkBit("model dut1 glitch", glitch1, m1.glitch);
      checkBit("rise/fall exclusive", rise0 & fall0, 1'b0);
    end
  end

  task automatic applyStimulus(input logic a, input logic r, input int cycles);
    a_async = a;
    rst     = r;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string name, input int sel, input logic ec,
                             input logic er, input logic ef, input logic eg);
    if (sel == 0) begin
      checkBit({name, " clean"},  clean0,  ec);
      checkBit({name, " rise"},   rise0,   er);
      checkBit({name, " fall"},   fall0,   ef);
      checkBit({name, " glitch"}, glitch0, eg);
    end else begin
      checkBit({name, " clean"},  clean1,  ec);
      checkBit({name, " rise"},   rise1,   er);
      checkBit({name, " fall"},   fall1,   ef);
      checkBit({name, " glitch"}, glitch1, eg);
    end
  endtask

  initial begin
    m0       = '0;
    m1       = '0;
    started  = 1'b0;
    n_assert = 0;
    n_fail   = 0;
    a_async  = 1'b1;
    rst      = 1'b1;

    $display("[TB] reset with input high");
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("reset edge1 dut0", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset edge1 dut1", 1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("reset edge2 dut0", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("after reset dut0", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 6);

    $display("[TB] clean rising step");
    applyStimulus(1'b1, 1'b0, 5);
    checkOutput("step edge5", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("step edge6", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("step edge7", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] falling edge, fast instance and default instance");
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("fast fall k+2", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("fast fall k+3", 1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("fast fall k+4", 1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("default fall edge5", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("default fall edge6", 0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("default fall edge8", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] short bounce");
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("bounce edge5", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("bounce edge6", 0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("bounce edge7", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4);

    $display("[TB] bounce then settle");
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("settle edge4", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("settle edge5", 0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("settle edge8", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("settle edge9", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("settle edge10", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8);
    checkOutput("settle low", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset mid-transition");
    applyStimulus(1'b1, 1'b0, 4);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("mid reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 5);
    checkOutput("post reset edge5", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("post reset edge6", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3);

    $display("[TB] fast toggling");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 2);
      applyStimulus(1'b1, 1'b0, 2);
    end
    checkOutput("toggle hold", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
